collision_detect: RTL
=====================

// Module: collision_detect
// PURPOSE
//  Datapath-side collision checker for the flappy-bird game. Consumes the
//  frame-update request from the bird/wall controllers, snapshots bird and
//  wall positions, and returns the sticky collision flag (touched) that both
//  controllers sample. Also keeps the walls-passed score for the display.
// PARAMETERS
//  X_W       8    width of horizontal coordinates
//  Y_W       7    width of vertical coordinates
//  BIRD_X    20   fixed left column of the bird
//  BIRD_SZ   4    bird width and height in pixels
//  WALL_W    8    wall width in pixels
//  GAP_H     24   height of the wall opening in pixels
//  SCREEN_H  120  screen height in pixels (used only by GROUND_HIT_EN)
//  SCORE_W   8    score counter width
// PORTS
//  clk      in   1        system clock
//  resetn   in   1        async active-low reset
//  check    in   1        1-cycle request: evaluate current positions
//  clear    in   1        sync restart: clears touched and score
//  bird_y   in   Y_W      bird top row
//  wall_x   in   X_W      wall left column
//  gap_y    in   Y_W      top row of wall opening
//  touched  out  1        sticky collision flag to the controllers
//  done     out  1        1-cycle pulse: result of the last check valid
//  score    out  SCORE_W  walls passed since clear, saturating
// BEHAVIOUR
//  - Reset (resetn=0, async): state=IDLE; touched=0, done=0, score=0,
//    passed_q=0, snapshot registers=0.
//  - FSM: IDLE -> SNAP -> CMP -> UPD -> IDLE.
//    IDLE: check=1 latches bird_y/wall_x/gap_y into snapshot, goes to SNAP.
//    SNAP: registers x_hit and y_hit from the snapshot.
//    CMP:  hit = x_hit & y_hit; passed = trailing edge < BIRD_X.
//    UPD:  touched |= hit; score update; done=1 for this cycle only.
//  - Latency: check sampled at edge N -> done high during cycle N+3.
//    Results are visible on touched/score in the same cycle as done.
//  - check is ignored outside IDLE; a check coincident with done is dropped.
//    There is no queue.
//  - Arithmetic: all sums use X_W+1 / Y_W+1 bits; no wrap.
//    x_hit = (wall_x <= BIRD_X+BIRD_SZ-1) && (wall_x+WALL_W-1 >= BIRD_X).
//    y_hit = (bird_y < gap_y) || (bird_y+BIRD_SZ-1 > gap_y+GAP_H-1).
//  - Score: in UPD, increment when passed=1 and passed_q=0 and the result
//    (touched after update) is 0. Then passed_q<=passed. Saturates at
//    2^SCORE_W-1. When the wall wraps back to the right edge, passed
//    returns to 0 and re-arms the increment.
//  - touched is sticky until clear or reset. Checks still run while
//    touched=1 (done still pulses), but score is frozen.
//  - clear has priority over everything, including a check in the same
//    cycle or mid-operation. Next state=IDLE; touched=0, score=0,
//    passed_q=0, done=0. The in-flight check is discarded (no done pulse).
// CONFIGURATION
//  GROUND_HIT_EN defined: y_hit also true when
//    bird_y+BIRD_SZ-1 >= SCREEN_H-1, regardless of x_hit. The floor is then
//    a collision anywhere on screen.
//  GROUND_HIT_EN undefined: only wall overlap counts; SCREEN_H is unused.
// TESTING
//  1. wall_x=18, gap_y=40, bird_y=50, check@N -> done@N+3, touched=0,
//     score=0.
//  2. wall_x=18, gap_y=40, bird_y=30, check -> touched=1 with done;
//     stays 1 through 5 further checks; later passes do not raise score.
//  3. bird_y=50, gap_y=40, checks at wall_x=30, 20, 12
//     (trailing edges 37, 27, 19) -> score 0, 0, 1.
//     Repeat wall_x=12 -> score stays 1.
//  4. check pulsed again at N+1 and N+2 -> exactly one done pulse at N+3.
//  5. clear at N+2 after a colliding check -> no done; touched=0, score=0,
//     state IDLE. A new check at N+4 gives done at N+7.
//  6. With GROUND_HIT_EN: wall_x=100, bird_y=116 -> touched=1.
//     Without GROUND_HIT_EN: same stimulus -> touched=0.
//  Each scenario also asserts resetn low mid-check: all outputs return to 0
//  asynchronously.

Source files
------------

// File: rtl/collision_detect_if.sv
// Frame-update handshake between the bird/wall controllers and the collision checker.
interface collision_detect_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int SCORE_W = 8
);
    logic               check;
    logic               clear;
    logic [Y_W-1:0]     bird_y;
    logic [X_W-1:0]     wall_x;
    logic [Y_W-1:0]     gap_y;
    logic               touched;
    logic               done;
    logic [SCORE_W-1:0] score;

    modport master (output check, clear, bird_y, wall_x, gap_y,
                    input  touched, done, score);
    modport slave  (input  check, clear, bird_y, wall_x, gap_y,
                    output touched, done, score);
endinterface

// File: rtl/collision_detect.sv
// Flappy-bird collision checker: snapshot -> compare -> update, sticky touched flag and score.
// Define GROUND_HIT_EN to also treat reaching the floor as a collision anywhere on screen.
module collision_detect #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int BIRD_X   = 20,
    parameter int BIRD_SZ  = 4,
    parameter int WALL_W   = 8,
    parameter int GAP_H    = 24,
    parameter int SCREEN_H = 120,
    parameter int SCORE_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    collision_detect_if.slave bus
);
    localparam int XW1 = X_W + 1;
    localparam int YW1 = Y_W + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SNAP = 2'd1;
    localparam logic [1:0] CMP  = 2'd2;
    localparam logic [1:0] UPD  = 2'd3;

    // One extra bit on every sum so edge positions never wrap.
    localparam logic [X_W:0] BX_L   = XW1'(BIRD_X);
    localparam logic [X_W:0] BX_R   = XW1'(BIRD_X + BIRD_SZ - 1);
    localparam logic [X_W:0] WW_M1  = XW1'(WALL_W - 1);
    localparam logic [Y_W:0] BSZ_M1 = YW1'(BIRD_SZ - 1);
    localparam logic [Y_W:0] GAP_M1 = YW1'(GAP_H - 1);

    logic [1:0]         state;
    logic [Y_W-1:0]     s_bird_y;
    logic [X_W-1:0]     s_wall_x;
    logic [Y_W-1:0]     s_gap_y;
    logic               x_hit, y_hit, g_hit;
    logic               hit, passed, passed_q;
    logic               touched_q, done_q;
    logic [SCORE_W-1:0] score_q;

    logic [X_W:0] wall_r;
    logic [Y_W:0] bird_b, gap_b;
    logic         x_hit_d, y_hit_d, g_hit_d, passed_d, touched_nx;

    always_comb begin
        wall_r     = {1'b0, s_wall_x} + WW_M1;
        bird_b     = {1'b0, s_bird_y} + BSZ_M1;
        gap_b      = {1'b0, s_gap_y} + GAP_M1;
        x_hit_d    = ({1'b0, s_wall_x} <= BX_R) && (wall_r >= BX_L);
        y_hit_d    = (s_bird_y < s_gap_y) || (bird_b > gap_b);
        passed_d   = wall_r < BX_L;
        touched_nx = touched_q | hit;
    end

`ifdef GROUND_HIT_EN
    localparam logic [Y_W:0] FLOOR = YW1'(SCREEN_H - 1);
    assign g_hit_d = bird_b >= FLOOR;
`else
    logic unused_screen_h;
    assign unused_screen_h = |SCREEN_H;
    assign g_hit_d         = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            s_bird_y  <= '0;
            s_wall_x  <= '0;
            s_gap_y   <= '0;
            x_hit     <= 1'b0;
            y_hit     <= 1'b0;
            g_hit     <= 1'b0;
            hit       <= 1'b0;
            passed    <= 1'b0;
            passed_q  <= 1'b0;
            touched_q <= 1'b0;
            done_q    <= 1'b0;
            score_q   <= '0;
        end else if (bus.clear) begin
            // Restart wins over any check, including one already in flight.
            state     <= IDLE;
            passed_q  <= 1'b0;
            touched_q <= 1'b0;
            done_q    <= 1'b0;
            score_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.check && !done_q) begin
                    s_bird_y <= bus.bird_y;
                    s_wall_x <= bus.wall_x;
                    s_gap_y  <= bus.gap_y;
                    state    <= SNAP;
                end
                SNAP: begin
                    x_hit <= x_hit_d;
                    y_hit <= y_hit_d;
                    g_hit <= g_hit_d;
                    state <= CMP;
                end
                CMP: begin
                    hit    <= (x_hit & y_hit) | g_hit;
                    passed <= passed_d;
                    state  <= UPD;
                end
                default: begin
                    touched_q <= touched_nx;
                    if (passed && !passed_q && !touched_nx && (score_q != '1))
                        score_q <= score_q + SCORE_W'(1);
                    passed_q <= passed;
                    done_q   <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.touched = touched_q;
    assign bus.done    = done_q;
    assign bus.score   = score_q;
endmodule
